// File: rtl/multicycle_main_control.sv
// ---------------------------------------------------------------------------
// multicycle_main_control
//   Multi-cycle main control FSM for the RV32I core. Sequences
//   FETCH/DECODE/EXEC/MEM/WB over a shared ALU and one memory port, with a
//   req/ack memory handshake, a bus timeout and a sticky trap state.
//
//   Build option: MAIN_CTRL_ILLEGAL_TRAP_EN
//     defined   : illegal opcode in DECODE traps with cause 01
//     undefined : illegal opcode is a NOP (DECODE -> FETCH)
//
//   Ports:
//     i_clk, i_rst           clock, async active-high reset
//     i_OPCode               opcode field of the instruction register
//     i_MemAck               memory done (may coincide with o_MemReq)
//     i_BranchTaken          branch comparator result
//     o_MemReq/o_MemWrite    memory request / write strobe
//     o_IorD                 address select (0 PC, 1 ALUOut)
//     o_IRWrite/o_MDRWrite   IR (and old PC) load / MDR load
//     o_PCWrite/o_PCSrc      PC update and source
//     o_ALUSrc1/2, o_ALUOp   ALU operand selects and operation class
//     o_MemToReg/o_RegWrite  writeback select / enable
//     o_Trap/o_TrapCause     sticky trap flag and cause
//     o_State                current state (debug)
// ---------------------------------------------------------------------------
module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_OPCode,
  input  logic       i_MemAck,
  input  logic       i_BranchTaken,
  output logic       o_MemReq,
  output logic       o_MemWrite,
  output logic       o_IorD,
  output logic       o_IRWrite,
  output logic       o_MDRWrite,
  output logic       o_PCWrite,
  output logic [1:0] o_PCSrc,
  output logic [1:0] o_ALUSrc1,
  output logic [1:0] o_ALUSrc2,
  output logic [2:0] o_ALUOp,
  output logic [1:0] o_MemToReg,
  output logic       o_RegWrite,
  output logic       o_Trap,
  output logic [1:0] o_TrapCause,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
  } cls_t;

  localparam logic [TO_CNT_W:0] TO_LIMIT = (TO_CNT_W+1)'(MEM_TIMEOUT);
  localparam bit                TO_EN    = (MEM_TIMEOUT != 0);

  state_t              state_q, state_d, st;
  cls_t                cls_q, cls_d, dec_cls;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic [TO_CNT_W:0]   cnt_inc;
  logic                req_state, stall, timeout_hit;

  // Reset forces the effective state to IDLE combinationally so every
  // output (notably MemReq/MemWrite) drops the instant reset rises.
  assign st          = i_rst ? S_IDLE : state_q;
  assign req_state   = (st == S_FETCH) || (st == S_MEM);
  assign stall       = req_state && !i_MemAck;
  assign cnt_inc     = {1'b0, to_cnt_q} + 1'b1;
  // This stall cycle is the MEM_TIMEOUT-th without ack; an ack wins.
  assign timeout_hit = TO_EN && stall && (cnt_inc >= TO_LIMIT);

  always_comb begin
    dec_cls = C_NONE;
    case (i_OPCode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d     = st;
    cls_d       = cls_q;
    o_MemReq    = 1'b0;
    o_MemWrite  = 1'b0;
    o_IorD      = 1'b0;
    o_IRWrite   = 1'b0;
    o_MDRWrite  = 1'b0;
    o_PCWrite   = 1'b0;
    o_PCSrc     = 2'd0;
    o_ALUSrc1   = 2'd0;
    o_ALUSrc2   = 2'd0;
    o_ALUOp     = 3'b000;
    o_MemToReg  = 2'd0;
    o_RegWrite  = 1'b0;
    case (st)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        o_MemReq = 1'b1;
        if (i_MemAck) begin
          o_IRWrite = 1'b1;
          o_PCWrite = 1'b1;
          o_ALUSrc1 = 2'd3;
          o_ALUSrc2 = 2'd2;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls != C_NONE) state_d = S_EXEC;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        else                   state_d = S_TRAP;
`else
        else                   state_d = S_FETCH;
`endif
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          C_R:      o_ALUOp = 3'b010;
          C_I:      begin o_ALUSrc2 = 2'd1; o_ALUOp = 3'b011; end
          C_LOAD, C_STORE: begin o_ALUSrc2 = 2'd1; state_d = S_MEM; end
          C_BRANCH: begin
            o_ALUOp   = 3'b001;
            o_PCSrc   = 2'd1;
            o_PCWrite = i_BranchTaken;
            state_d   = S_FETCH;
          end
          C_LUI:    begin o_ALUSrc1 = 2'd2; o_ALUSrc2 = 2'd1; o_ALUOp = 3'b100; end
          C_AUIPC:  begin o_ALUSrc1 = 2'd1; o_ALUSrc2 = 2'd1; o_ALUOp = 3'b101; end
          C_JAL:    begin o_PCSrc = 2'd1; o_PCWrite = 1'b1; end
          C_JALR:   begin o_ALUSrc2 = 2'd1; o_PCSrc = 2'd2; o_PCWrite = 1'b1; end
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        o_MemReq   = 1'b1;
        o_IorD     = 1'b1;
        o_MemWrite = (cls_q == C_STORE);
        if (i_MemAck) begin
          o_MDRWrite = (cls_q == C_LOAD);
          state_d    = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        o_RegWrite = 1'b1;
        if (cls_q == C_LOAD)                          o_MemToReg = 2'd1;
        else if (cls_q == C_JAL || cls_q == C_JALR)   o_MemToReg = 2'd2;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: cleared on entry to a request state, saturating.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != st)
      to_cnt_d = '0;
    else if (stall && to_cnt_q != {TO_CNT_W{1'b1}})
      to_cnt_d = cnt_inc[TO_CNT_W-1:0];
  end

  // Cause is captured on the transition into TRAP; DECODE is the only
  // source of an illegal-opcode trap, everything else is a bus timeout.
  always_comb begin
    cause_d = cause_q;
    if (state_d == S_TRAP && st != S_TRAP)
      cause_d = (st == S_DECODE) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cls_q    <= C_NONE;
      to_cnt_q <= '0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      to_cnt_q <= to_cnt_d;
      cause_q  <= cause_d;
    end
  end

  assign o_Trap      = (st == S_TRAP);
  assign o_TrapCause = i_rst ? 2'b00 : cause_q;
  assign o_State     = st;

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;
  localparam int TO = 4;

  localparam logic [6:0] OP_R   = 7'b0110011, OP_I     = 7'b0010011,
                         OP_LD  = 7'b0000011, OP_ST    = 7'b0100011,
                         OP_BR  = 7'b1100011, OP_LUI   = 7'b0110111,
                         OP_AUI = 7'b0010111, OP_JAL   = 7'b1101111,
                         OP_JALR= 7'b1100111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic       ack, bt;
  logic       mreq, mwr, iord, irw, mdrw, pcw, regw, trap;
  logic [1:0] pcsrc, a1, a2, m2r, cause;
  logic [2:0] aluop, st;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(TO), .TO_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_OPCode(opc), .i_MemAck(ack),
    .i_BranchTaken(bt), .o_MemReq(mreq), .o_MemWrite(mwr), .o_IorD(iord),
    .o_IRWrite(irw), .o_MDRWrite(mdrw), .o_PCWrite(pcw), .o_PCSrc(pcsrc),
    .o_ALUSrc1(a1), .o_ALUSrc2(a2), .o_ALUOp(aluop), .o_MemToReg(m2r),
    .o_RegWrite(regw), .o_Trap(trap), .o_TrapCause(cause), .o_State(st)
  );

  typedef struct packed {
    logic       memreq, memwrite, iord, irw, mdrw, pcw;
    logic [1:0] pcsrc, a1, a2;
    logic [2:0] aluop;
    logic [1:0] m2r;
    logic       regw, trap;
    logic [1:0] cause;
    logic [2:0] st;
  } ov_t;

  ov_t got;
  assign got = {mreq, mwr, iord, irw, mdrw, pcw, pcsrc, a1, a2, aluop,
                m2r, regw, trap, cause, st};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input ov_t g, input ov_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, g, e, $time);
    end
  endtask

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock: drive inputs after the falling edge, then compare.
  task automatic cyc(input string tag, input logic [6:0] o, input logic a,
                     input logic b, input ov_t e);
    @(negedge clk);
    opc = o; ack = a; bt = b;
    #1 chk(tag, got, e);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 chk("rst_async", got, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_idle", got, '0);
  endtask

  task automatic trap_phase(input logic [1:0] c);
    ov_t e;
    e = '0; e.trap = 1'b1; e.cause = c; e.st = 3'd6;
    repeat (3) cyc("trap_hold", junk(), rb(), rb(), e);
    do_reset();
  endtask

  // Waiting cycles of a request phase; a request left unacked for TO
  // cycles ends up in TRAP with cause 10 instead.
  task automatic stall_phase(input bit is_mem, input bit is_st, input int w,
                             output bit trapped);
    ov_t   e;
    int    n;
    string tag;
    tag = is_mem ? "mem_wait" : "fetch_wait";
    trapped = (TO != 0) && (w >= TO);
    n = trapped ? TO : w;
    e = '0; e.memreq = 1'b1; e.iord = is_mem; e.memwrite = is_st;
    e.st = is_mem ? 3'd4 : 3'd1;
    for (int i = 0; i < n; i++) cyc(tag, junk(), 1'b0, rb(), e);
    if (trapped) trap_phase(2'b10);
  endtask

  function automatic bit is_valid(input logic [6:0] o);
    return o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
  endfunction

  // Instruction-level reference: the sequence of control words that one
  // instruction must produce, given its opcode and the memory wait counts.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                           input logic b);
    ov_t e;
    bit  tr;
    bit  is_ld, is_st;
    is_ld = (o == OP_LD);
    is_st = (o == OP_ST);
    stall_phase(1'b0, 1'b0, fw, tr);
    if (tr) return;
    e = '0; e.memreq = 1; e.irw = 1; e.pcw = 1; e.a1 = 2'd3; e.a2 = 2'd2; e.st = 3'd1;
    cyc("fetch_ack", junk(), 1'b1, rb(), e);
    e = '0; e.st = 3'd2;
    cyc("decode", o, rb(), rb(), e);
    if (!is_valid(o)) begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      trap_phase(2'b01);
`endif
      return;
    end
    e = '0; e.st = 3'd3;
    case (o)
      OP_R:    e.aluop = 3'b010;
      OP_I:    begin e.a2 = 2'd1; e.aluop = 3'b011; end
      OP_LD, OP_ST: e.a2 = 2'd1;
      OP_BR:   begin e.aluop = 3'b001; e.pcsrc = 2'd1; e.pcw = b; end
      OP_LUI:  begin e.a1 = 2'd2; e.a2 = 2'd1; e.aluop = 3'b100; end
      OP_AUI:  begin e.a1 = 2'd1; e.a2 = 2'd1; e.aluop = 3'b101; end
      OP_JAL:  begin e.pcsrc = 2'd1; e.pcw = 1'b1; end
      default: begin e.a2 = 2'd1; e.pcsrc = 2'd2; e.pcw = 1'b1; end
    endcase
    cyc("exec", junk(), rb(), b, e);
    if (o == OP_BR) return;
    if (is_ld || is_st) begin
      stall_phase(1'b1, is_st, mw, tr);
      if (tr) return;
      e = '0; e.memreq = 1; e.iord = 1; e.memwrite = is_st; e.mdrw = is_ld; e.st = 3'd4;
      cyc("mem_ack", junk(), 1'b1, rb(), e);
      if (is_st) return;
    end
    e = '0; e.regw = 1'b1; e.st = 3'd5;
    e.m2r = is_ld ? 2'd1 : ((o == OP_JAL || o == OP_JALR) ? 2'd2 : 2'd0);
    cyc("wb", junk(), rb(), rb(), e);
  endtask

  logic [6:0] ops [13];

  initial begin
    ov_t e;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR,
            7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};
    rst = 1'b1; opc = '0; ack = 1'b0; bt = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LD, 0, 3, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b1);
    run_instr(OP_JALR, 0, 0, 1'b0);
    run_instr(OP_ST, TO-1, TO-1, 1'b0);   // acks on the last allowed cycle
    run_instr(OP_R, TO, 0, 1'b0);         // fetch timeout -> TRAP
    run_instr(OP_LD, 0, TO, 1'b0);        // memory timeout -> TRAP
    run_instr(7'b1111111, 0, 0, 1'b0);    // illegal opcode

    // Reset in the middle of a stalled fetch.
    e = '0; e.memreq = 1'b1; e.st = 3'd1;
    cyc("fetch_wait", junk(), 1'b0, 1'b0, e);
    do_reset();

    for (int k = 0; k < 250; k++)
      run_instr(ops[$urandom_range(12)], $urandom_range(TO+1),
                $urandom_range(TO+1), rb());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, required finish before 900000");
    $fatal(1);
  end
endmodule
